// File: rtl/ctrl_port.sv
// Standard controller port responder for CPU $4016/$4017: strobe latch plus per-pad serial shift.
// Optional macro CTRL_PORT2_EN keeps the pad-2 path; without it $4017 reads return {OPEN_BUS, 0}.
module ctrl_port #(
  parameter logic [6:0] OPEN_BUS = 7'b0100000
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic        clock_en,
  input  logic [15:0] addr,
  input  logic        r_en,
  input  logic [7:0]  w_data,
  output logic [7:0]  r_data,
  output logic        hit,
  input  logic [7:0]  btn0,
  input  logic [7:0]  btn1
);

  logic       w_rd0;
  logic       w_rd1;
  logic       w_wr0;
  logic       w_bit0;
  logic       w_bit1;

  logic [7:0] r_sync0_a;
  logic [7:0] r_sync0_b;
  logic       r_strobe;
  logic [7:0] r_sh0;
  logic [3:0] r_cnt0;

  assign w_rd0 = r_en && (addr == 16'h4016);
  assign w_rd1 = r_en && (addr == 16'h4017);
  // Writes to $4017 belong to the APU frame counter and are left alone.
  assign w_wr0 = !r_en && (addr == 16'h4016);
  assign hit   = w_rd0 || w_rd1 || w_wr0;

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      r_sync0_a <= 8'h00;
      r_sync0_b <= 8'h00;
    end else begin
      r_sync0_a <= btn0;
      r_sync0_b <= r_sync0_a;
    end
  end

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      r_strobe <= 1'b0;
    end else if (clock_en && w_wr0) begin
      r_strobe <= w_data[0];
    end
  end

  // Reload uses the strobe value before this edge, so the clearing write still samples.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      r_sh0  <= 8'h00;
      r_cnt0 <= 4'd0;
    end else if (clock_en) begin
      if (r_strobe) begin
        r_sh0  <= r_sync0_b;
        r_cnt0 <= 4'd0;
      end else if (w_rd0 && (r_cnt0 < 4'd8)) begin
        r_sh0  <= {1'b1, r_sh0[7:1]};
        r_cnt0 <= r_cnt0 + 4'd1;
      end
    end
  end

  assign w_bit0 = r_strobe ? r_sync0_b[0] : ((r_cnt0 == 4'd8) ? 1'b1 : r_sh0[0]);

`ifdef CTRL_PORT2_EN
  logic [7:0] r_sync1_a;
  logic [7:0] r_sync1_b;
  logic [7:0] r_sh1;
  logic [3:0] r_cnt1;

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      r_sync1_a <= 8'h00;
      r_sync1_b <= 8'h00;
    end else begin
      r_sync1_a <= btn1;
      r_sync1_b <= r_sync1_a;
    end
  end

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      r_sh1  <= 8'h00;
      r_cnt1 <= 4'd0;
    end else if (clock_en) begin
      if (r_strobe) begin
        r_sh1  <= r_sync1_b;
        r_cnt1 <= 4'd0;
      end else if (w_rd1 && (r_cnt1 < 4'd8)) begin
        r_sh1  <= {1'b1, r_sh1[7:1]};
        r_cnt1 <= r_cnt1 + 4'd1;
      end
    end
  end

  assign w_bit1 = r_strobe ? r_sync1_b[0] : ((r_cnt1 == 4'd8) ? 1'b1 : r_sh1[0]);
`else
  logic w_unused_btn1;
  assign w_unused_btn1 = ^btn1;
  assign w_bit1        = 1'b0;
`endif

  always_comb begin
    r_data = 8'h00;
    if (w_rd0) begin
      r_data = {OPEN_BUS, w_bit0};
    end else if (w_rd1) begin
      r_data = {OPEN_BUS, w_bit1};
    end
  end

endmodule

// File: tb/tb_ctrl_port.sv
// Directed and randomized bench for ctrl_port against a queue-based model of the pad shift behaviour.
// Build with or without CTRL_PORT2_EN; pad-2 expectations follow the macro.
module tb_ctrl_port;

`ifdef CTRL_PORT2_EN
  localparam bit P2_EN = 1'b1;
`else
  localparam bit P2_EN = 1'b0;
`endif

  logic        clock;
  logic        reset_n;
  logic        clock_en;
  logic [15:0] addr;
  logic        r_en;
  logic [7:0]  w_data;
  logic [7:0]  r_data;
  logic        hit;
  logic [7:0]  btn0;
  logic [7:0]  btn1;

  int n_vec;
  int n_fail;

  // Model: strobe flag plus a queue of bits still to be reported per pad.
  bit         m_strobe;
  bit         m_q0[$];
  bit         m_q1[$];
  logic [7:0] m_btn0;
  logic [7:0] m_btn1;

  ctrl_port dut (
    .clock    (clock),
    .reset_n  (reset_n),
    .clock_en (clock_en),
    .addr     (addr),
    .r_en     (r_en),
    .w_data   (w_data),
    .r_data   (r_data),
    .hit      (hit),
    .btn0     (btn0),
    .btn1     (btn1)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic bit pad_bit(input bit strobe, input logic [7:0] btn, input bit q[$]);
    if (strobe) return btn[0];
    if (q.size() == 0) return 1'b1;
    return q[0];
  endfunction

  function automatic logic [7:0] exp_data(input logic [15:0] a, input logic rd);
    if (rd && a == 16'h4016) return {7'b0100000, pad_bit(m_strobe, m_btn0, m_q0)};
    if (rd && a == 16'h4017) begin
      if (!P2_EN) return 8'h40;
      return {7'b0100000, pad_bit(m_strobe, m_btn1, m_q1)};
    end
    return 8'h00;
  endfunction

  function automatic logic exp_hit(input logic [15:0] a, input logic rd);
    return (a == 16'h4016) || (rd && a == 16'h4017);
  endfunction

  task automatic model_reset();
    m_strobe = 1'b0;
    m_q0.delete();
    m_q1.delete();
    for (int i = 0; i < 8; i++) begin
      m_q0.push_back(1'b0);
      m_q1.push_back(1'b0);
    end
  endtask

  task automatic model_edge(input logic [15:0] a, input logic rd, input logic [7:0] wd);
    if (m_strobe) begin
      m_q0.delete();
      m_q1.delete();
      for (int i = 0; i < 8; i++) begin
        m_q0.push_back(m_btn0[i]);
        m_q1.push_back(m_btn1[i]);
      end
    end else begin
      if (rd && a == 16'h4016 && m_q0.size() > 0) void'(m_q0.pop_front());
      if (rd && a == 16'h4017 && P2_EN && m_q1.size() > 0) void'(m_q1.pop_front());
    end
    if (!rd && a == 16'h4016) m_strobe = wd[0];
  endtask

  // One CPU cycle of len master clocks; clock_en fires on the last of them.
  task automatic cpu_cycle(input logic [15:0] a, input logic rd, input logic [7:0] wd, input int len);
    @(negedge clock);
    addr     = a;
    r_en     = rd;
    w_data   = wd;
    clock_en = (len == 1);
    #1;
    chk("hit", {7'd0, hit}, {7'd0, exp_hit(a, rd)});
    if (rd || !exp_hit(a, rd)) chk("r_data", r_data, exp_data(a, rd));
    for (int k = 1; k < len; k++) begin
      @(negedge clock);
      clock_en = (k == len - 1);
    end
    if (len > 1 && rd) begin
      #1;
      chk("r_data_held", r_data, exp_data(a, rd));
    end
    @(posedge clock);
    model_edge(a, rd, wd);
    #1;
    clock_en = 1'b0;
  endtask

  task automatic rd(input logic [15:0] a);
    cpu_cycle(a, 1'b1, 8'h00, 1);
  endtask

  task automatic wr(input logic [15:0] a, input logic [7:0] d);
    cpu_cycle(a, 1'b0, d, 1);
  endtask

  // Buttons settle through the synchronizers with clock_en held low.
  task automatic set_btn(input logic [7:0] b0, input logic [7:0] b1);
    @(negedge clock);
    clock_en = 1'b0;
    btn0     = b0;
    btn1     = b1;
    m_btn0   = b0;
    m_btn1   = b1;
    repeat (3) @(negedge clock);
  endtask

  task automatic do_reset();
    @(negedge clock);
    reset_n  = 1'b0;
    clock_en = 1'b0;
    addr     = 16'h0000;
    r_en     = 1'b1;
    repeat (2) @(posedge clock);
    @(negedge clock);
    chk("reset_hit", {7'd0, hit}, 8'h00);
    chk("reset_r_data", r_data, 8'h00);
    reset_n = 1'b1;
    model_reset();
    repeat (3) @(negedge clock);
  endtask

  initial begin
    logic [15:0] ra;
    logic        rr;
    int unsigned sel;

    n_vec    = 0;
    n_fail   = 0;
    reset_n  = 1'b0;
    clock_en = 1'b0;
    addr     = 16'h0000;
    r_en     = 1'b1;
    w_data   = 8'h00;
    btn0     = 8'h00;
    btn1     = 8'h00;
    m_btn0   = 8'h00;
    m_btn1   = 8'h00;
    model_reset();

    do_reset();
    repeat (10) rd(16'h4016);

    set_btn(8'b1000_0101, 8'h00);
    wr(16'h4016, 8'h01);
    wr(16'h4016, 8'h00);
    repeat (9) rd(16'h4016);

    set_btn(8'h00, 8'h00);
    wr(16'h4016, 8'hFF);
    rd(16'h4016);
    set_btn(8'h01, 8'h00);
    rd(16'h4016);
    rd(16'h4016);
    wr(16'h4016, 8'hFE);

    set_btn(8'h01, 8'h02);
    wr(16'h4016, 8'h01);
    wr(16'h4016, 8'h00);
    rd(16'h4016);
    rd(16'h4017);
    rd(16'h4016);
    rd(16'h4017);

    set_btn(8'b0000_0110, 8'h5A);
    wr(16'h4016, 8'h01);
    wr(16'h4016, 8'h00);
    cpu_cycle(16'h4016, 1'b1, 8'h00, 12);
    cpu_cycle(16'h4016, 1'b1, 8'h00, 12);
    cpu_cycle(16'h4017, 1'b0, 8'h01, 1);
    repeat (2) rd(16'h4016);

    set_btn(8'hFF, 8'hFF);
    wr(16'h4016, 8'h01);
    wr(16'h4016, 8'h00);
    repeat (3) rd(16'h4016);
    do_reset();
    repeat (9) rd(16'h4016);
    repeat (3) rd(16'h4017);

    for (int n = 0; n < 150; n++) begin
      sel = $urandom_range(0, 9);
      case (sel)
        0:       set_btn(8'($urandom), 8'($urandom));
        1:       wr(16'h4016, 8'($urandom_range(0, 1)));
        2:       wr(16'h4017, 8'($urandom));
        3: begin
          ra = 16'($urandom);
          rr = 1'($urandom_range(0, 1));
          cpu_cycle(ra, rr, 8'($urandom), $urandom_range(1, 3));
        end
        4, 5, 6: cpu_cycle(16'h4016, 1'b1, 8'h00, $urandom_range(1, 4));
        default: cpu_cycle(16'h4017, 1'b1, 8'h00, $urandom_range(1, 4));
      endcase
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
